// File: rtl/intr_sequencer.sv
// intr_sequencer: interrupt entry/exit sequencer (freeze, drain, push return PC, vector, ISR).
// Define INTR_SYNC_EN to pass INTR_IN through a two-flop synchronizer before edge detection.
module intr_sequencer #(
  parameter int PC_W = 8,
  parameter int DRAIN_CYCLES = 3,
  parameter logic [PC_W-1:0] VECTOR_ADDR = 8'h01
) (
  input  logic            CLK,
  input  logic            RESET_IN,
  input  logic            INTR_IN,
  input  logic [PC_W-1:0] pc_i,
  input  logic            stall_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_target_i,
  input  logic            push_ack_i,
  input  logic            rti_i,
  output logic            pc_hold_o,
  output logic            flush_o,
  output logic            push_req_o,
  output logic [PC_W-1:0] ret_pc_o,
  output logic            vec_load_o,
  output logic [PC_W-1:0] vec_addr_o,
  output logic            intr_ack_o,
  output logic            in_isr_o
);
  typedef enum logic [2:0] {IDLE, DRAIN, PUSH, VECTOR, ISR} state_t;
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);
  state_t state, state_d;
  logic intr_s, intr_q, rise, pending;
  logic [3:0] cnt;
  logic [PC_W-1:0] ret_pc;
`ifdef INTR_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge CLK) sync <= RESET_IN ? 2'b00 : {sync[0], INTR_IN};
  assign intr_s = sync[1];
`else
  assign intr_s = INTR_IN;
`endif
  assign rise = intr_s & ~intr_q;
  assign ret_pc_o = ret_pc;
  assign vec_addr_o = VECTOR_ADDR;
  always_ff @(posedge CLK) begin
    if (RESET_IN) begin
      state   <= IDLE;
      intr_q  <= 1'b0;
      pending <= 1'b0;
      cnt     <= '0;
      ret_pc  <= '0;
    end else begin
      state  <= state_d;
      intr_q <= intr_s;
      // a rise in the vector cycle must survive the clear so it is serviced after RTI
      if (rise) pending <= 1'b1;
      else if (state == VECTOR) pending <= 1'b0;
      if (state == IDLE && pending) begin
        ret_pc <= pc_i;
        cnt    <= DRAIN_LOAD;
      end else if (state == DRAIN) begin
        if (branch_taken_i) begin
          ret_pc <= branch_target_i;
          cnt    <= DRAIN_LOAD;
        end else if (!stall_i) cnt <= cnt - 4'd1;
      end
    end
  end
  always_comb begin
    state_d    = state;
    pc_hold_o  = 1'b0;
    flush_o    = 1'b0;
    push_req_o = 1'b0;
    vec_load_o = 1'b0;
    intr_ack_o = 1'b0;
    in_isr_o   = 1'b0;
    case (state)
      IDLE: state_d = pending ? DRAIN : IDLE;
      DRAIN: begin
        pc_hold_o = 1'b1;
        flush_o   = 1'b1;
        state_d   = (!branch_taken_i && !stall_i && cnt == 4'd1) ? PUSH : DRAIN;
      end
      PUSH: begin
        pc_hold_o  = 1'b1;
        flush_o    = 1'b1;
        push_req_o = 1'b1;
        state_d    = push_ack_i ? VECTOR : PUSH;
      end
      VECTOR: begin
        vec_load_o = 1'b1;
        intr_ack_o = 1'b1;
        flush_o    = 1'b1;
        state_d    = ISR;
      end
      ISR: begin
        in_isr_o = 1'b1;
        state_d  = rti_i ? IDLE : ISR;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
